fir_mac_engine: RTL and testbench

Parametrised FIR convolution engine, the successor to the fixed 16-bit single-rate FIR core. It reads coefficients and samples from external single-port synchronous RAMs (1-cycle read latency) and computes the full convolution of length taps+samples−1 in Q15 with rounding. It adds run-time decimation and writes results to an external result RAM. It sits between the coefficient/sample RAMs and the result RAM and is controlled by the top-level sequencer through start/busy/done.

---
 rtl/fir_mac_if.sv | 34 +++
 rtl/fir_mac_engine.sv | 182 ++++++++++++++++++
 tb/tb_fir_mac_engine.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_if.sv
// Bus bundle for fir_mac_engine: job control, coefficient/sample RAM reads and result RAM writes.
// master = sequencer/RAM side, slave = engine side.
interface fir_mac_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 21,
    parameter int TAP_AW = 5,
    parameter int SMP_AW = 13
);
    logic [TAP_AW:0]           cfg_taps;
    logic [SMP_AW:0]           cfg_samples;
    logic [3:0]                cfg_decim;
    logic                      start;
    logic                      busy;
    logic                      done;
    logic [TAP_AW-1:0]         coef_addr;
    logic signed [COEF_W-1:0]  coef_data;
    logic [SMP_AW-1:0]         smp_addr;
    logic signed [DATA_W-1:0]  smp_data;
    logic [SMP_AW:0]           res_addr;
    logic [OUT_W-1:0]          res_data;
    logic                      res_wr;
    logic                      sat_flag;

    modport master (
        output cfg_taps, cfg_samples, cfg_decim, start, coef_data, smp_data,
        input  busy, done, coef_addr, smp_addr, res_addr, res_data, res_wr, sat_flag
    );

    modport slave (
        input  cfg_taps, cfg_samples, cfg_decim, start, coef_data, smp_data,
        output busy, done, coef_addr, smp_addr, res_addr, res_data, res_wr, sat_flag
    );
endinterface

// File: rtl/fir_mac_engine.sv
// FIR convolution engine: reads coefficient/sample RAMs, writes rounded Q15 results with decimation.
// Define FIR_SAT_EN to clamp results and drive sticky sat_flag; otherwise results wrap.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | cfg latched, empty job check
// MAC   | issue reads for taps k = 0..T-1
// DRAIN | wait out RAM latency and product register
// WRITE | result presented to result RAM
// DONE  | one-cycle completion pulse
module fir_mac_engine #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 21,
    parameter int FRAC   = 15,
    parameter int TAP_AW = 5,
    parameter int SMP_AW = 13
) (
    input  logic     clk,
    input  logic     rst,
    fir_mac_if.slave bus
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + TAP_AW;
    localparam int IDX_W  = SMP_AW + 3;
    localparam logic signed [ACC_W-1:0] HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, WRITE, DONE} state_t;

    state_t state, state_nx;

    logic [TAP_AW:0]          taps_q;
    logic [SMP_AW:0]          smp_q;
    logic [3:0]               decim_q;
    logic [IDX_W-1:0]         n_q;
    logic [IDX_W-1:0]         sidx;
    logic [TAP_AW-1:0]        k_q;
    logic [TAP_AW:0]          cnt;
    logic                     v1;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  rnd;
    logic [SMP_AW:0]          res_addr_q;
    logic [OUT_W-1:0]         res_data_q;
    logic [OUT_W-1:0]         res_val;
    logic [3:0]               decim_eff;
    logic [IDX_W-1:0]         n_step;
    logic [IDX_W-1:0]         len;
    logic                     more;
    logic                     busy_c, done_c, wr_c;

    assign decim_eff = (decim_q == 4'd0) ? 4'd1 : decim_q;
    assign n_step    = n_q + IDX_W'(decim_eff);
    assign len       = IDX_W'(taps_q) + IDX_W'(smp_q) - IDX_W'(1);
    assign more      = n_step < len;
    assign acc_sum   = acc + ACC_W'(prod);
    assign rnd       = acc_sum + HALF;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        wr_c     = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nx = LOAD;
            LOAD:  begin
                busy_c   = 1'b1;
                state_nx = (taps_q == '0 || smp_q == '0) ? DONE : MAC;
            end
            MAC:   begin
                busy_c = 1'b1;
                if (cnt == '0) state_nx = DRAIN;
            end
            DRAIN: begin
                busy_c = 1'b1;
                if (cnt == '0) state_nx = WRITE;
            end
            WRITE: begin
                busy_c   = 1'b1;
                wr_c     = 1'b1;
                state_nx = more ? MAC : DONE;
            end
            DONE:  begin
                busy_c   = 1'b1;
                done_c   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // sidx tracks n-k; negative values wrap to huge unsigned and fail the range test
    always_ff @(posedge clk) begin
        if (rst) begin
            taps_q     <= '0;
            smp_q      <= '0;
            decim_q    <= '0;
            n_q        <= '0;
            sidx       <= '0;
            k_q        <= '0;
            cnt        <= '0;
            v1         <= 1'b0;
            prod       <= '0;
            acc        <= '0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            v1   <= (state == MAC) && (sidx < IDX_W'(smp_q));
            prod <= v1 ? PROD_W'(bus.coef_data) * PROD_W'(bus.smp_data) : '0;
            acc  <= acc_sum;
            case (state)
                IDLE: if (bus.start) begin
                    taps_q     <= bus.cfg_taps;
                    smp_q      <= bus.cfg_samples;
                    decim_q    <= bus.cfg_decim;
                    n_q        <= '0;
                    res_addr_q <= '0;
                end
                LOAD: begin
                    acc  <= '0;
                    k_q  <= '0;
                    sidx <= '0;
                    cnt  <= taps_q - 1'b1;
                end
                MAC: begin
                    k_q  <= k_q + 1'b1;
                    sidx <= sidx - IDX_W'(1);
                    cnt  <= (cnt == '0) ? (TAP_AW+1)'(1) : cnt - 1'b1;
                end
                DRAIN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) res_data_q <= res_val;
                end
                WRITE: begin
                    acc        <= '0;
                    k_q        <= '0;
                    n_q        <= n_step;
                    sidx       <= n_step;
                    cnt        <= taps_q - 1'b1;
                    res_addr_q <= res_addr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef FIR_SAT_EN
    logic signed [ACC_W-1:0] shifted;
    logic                    ovf;
    logic                    sat_q;

    assign shifted = rnd >>> FRAC;
    assign ovf     = !((&shifted[ACC_W-1:OUT_W-1]) || !(|shifted[ACC_W-1:OUT_W-1]));
    assign res_val = ovf ? (shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}})
                         : shifted[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst)                                  sat_q <= 1'b0;
        else if (state == IDLE && bus.start)      sat_q <= 1'b0;
        else if (state == DRAIN && cnt == '0 && ovf) sat_q <= 1'b1;
    end

    assign bus.sat_flag = sat_q;
`else
    assign res_val      = OUT_W'(rnd >>> FRAC);
    assign bus.sat_flag = 1'b0;
`endif

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.res_wr    = wr_c;
    assign bus.coef_addr = k_q;
    assign bus.smp_addr  = sidx[SMP_AW-1:0];
    assign bus.res_addr  = res_addr_q;
    assign bus.res_data  = res_data_q;
endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine: vector table of small jobs plus start-while-busy,
// empty-job and mid-job reset sequences. Built with OUT_W=16 so the saturation case applies.
module tb_fir_mac_engine;
    localparam int OUT_W = 16;

    logic clk = 1'b0;
    logic rst;

    fir_mac_if #(.OUT_W(OUT_W)) bus ();

    fir_mac_engine #(.OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic signed [15:0] coef_mem [0:31];
    logic signed [15:0] smp_mem  [0:8191];

    always @(posedge clk) begin
        bus.coef_data <= coef_mem[bus.coef_addr];
        bus.smp_data  <= smp_mem[bus.smp_addr];
    end

    int wr_cnt, busy_cnt, done_cnt;
    int res_val [0:7];
    int res_adr [0:7];

    always @(negedge clk) begin
        if (bus.busy) busy_cnt++;
        if (bus.done) done_cnt++;
        if (bus.res_wr) begin
            if (wr_cnt < 8) begin
                res_val[wr_cnt] = int'($signed(bus.res_data));
                res_adr[wr_cnt] = int'(bus.res_addr);
            end
            wr_cnt++;
        end
    end

    typedef struct {
        string name;
        int    taps;
        int    samples;
        int    decim;
        int    c [4];
        int    x [4];
        int    nout;
        int    exp_y [5];
        int    exp_busy;
        int    exp_sat;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];
    vec_t avg;
    vec_t empty;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic start_job(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            coef_mem[i] = 16'(v.c[i]);
            smp_mem[i]  = 16'(v.x[i]);
        end
        for (int i = 0; i < 8; i++) begin
            res_val[i] = 99999;
            res_adr[i] = -1;
        end
        @(negedge clk);
        wr_cnt   = 0;
        busy_cnt = 0;
        done_cnt = 0;
        bus.cfg_taps    = 6'(v.taps);
        bus.cfg_samples = 14'(v.samples);
        bus.cfg_decim   = 4'(v.decim);
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({name, ".done_seen"}, int'(bus.done), 1);
        @(negedge clk);
    endtask

    task automatic check_job(input vec_t v);
        chk({v.name, ".writes"}, wr_cnt, v.nout);
        chk({v.name, ".busy_cycles"}, busy_cnt, v.exp_busy);
        chk({v.name, ".done_pulses"}, done_cnt, 1);
        for (int j = 0; j < v.nout; j++) begin
            chk($sformatf("%s.y%0d", v.name, j), res_val[j], v.exp_y[j]);
            chk($sformatf("%s.addr%0d", v.name, j), res_adr[j], j);
        end
        chk({v.name, ".sat_flag"}, int'(bus.sat_flag), v.exp_sat);
    endtask

    task automatic check_zero(input string name);
        chk({name, ".busy"},      int'(bus.busy), 0);
        chk({name, ".done"},      int'(bus.done), 0);
        chk({name, ".res_wr"},    int'(bus.res_wr), 0);
        chk({name, ".sat_flag"},  int'(bus.sat_flag), 0);
        chk({name, ".coef_addr"}, int'(bus.coef_addr), 0);
        chk({name, ".smp_addr"},  int'(bus.smp_addr), 0);
        chk({name, ".res_addr"},  int'(bus.res_addr), 0);
        chk({name, ".res_data"},  int'(bus.res_data), 0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.cfg_taps    = '0;
        bus.cfg_samples = '0;
        bus.cfg_decim   = '0;
        for (int i = 0; i < 32; i++)   coef_mem[i] = '0;
        for (int i = 0; i < 8192; i++) smp_mem[i]  = '0;

        avg = '{name: "avg_d1", taps: 2, samples: 4, decim: 1,
                c: '{16384, 16384, 0, 0}, x: '{-1000, -2000, -3000, -4000},
                nout: 5, exp_y: '{-500, -1500, -2500, -3500, -2000}, exp_busy: 27, exp_sat: 0};
        vecs[0] = avg;
        vecs[1] = '{name: "invert", taps: 1, samples: 4, decim: 1,
                    c: '{-32768, 0, 0, 0}, x: '{1000, -2000, 3000, -4000},
                    nout: 4, exp_y: '{-1000, 2000, -3000, 4000, 0}, exp_busy: 18, exp_sat: 0};
        vecs[2] = avg;
        vecs[2].name = "avg_d2"; vecs[2].decim = 2; vecs[2].nout = 3;
        vecs[2].exp_y = '{-500, -2500, -2000, 0, 0}; vecs[2].exp_busy = 17;
        vecs[3] = avg;
        vecs[3].name = "avg_d0"; vecs[3].decim = 0;
        vecs[4] = avg;
        vecs[4].name = "avg_d3"; vecs[4].decim = 3; vecs[4].nout = 2;
        vecs[4].exp_y = '{-500, -3500, 0, 0, 0}; vecs[4].exp_busy = 12;
        vecs[5] = avg;
        vecs[5].name = "avg_d7"; vecs[5].decim = 7; vecs[5].nout = 1;
        vecs[5].exp_y = '{-500, 0, 0, 0, 0}; vecs[5].exp_busy = 7;
        vecs[6] = '{name: "sat", taps: 2, samples: 2, decim: 1,
                    c: '{32767, 32767, 0, 0}, x: '{32767, 32767, 0, 0},
                    nout: 3, exp_y: '{32766, -4, 32766, 0, 0}, exp_busy: 17, exp_sat: 0};
`ifdef FIR_SAT_EN
        vecs[6].exp_y[1] = 32767;
        vecs[6].exp_sat  = 1;
`endif
        empty = avg;
        empty.name = "n_zero"; empty.samples = 0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset");

        for (int v = 0; v < NV; v++) begin
            start_job(vecs[v]);
            wait_done(vecs[v].name);
            check_job(vecs[v]);
        end

        // empty jobs: also checks that start clears a sticky sat_flag
        start_job(empty);
        wait_done("n_zero");
        chk("n_zero.busy_cycles", busy_cnt, 2);
        chk("n_zero.done_pulses", done_cnt, 1);
        chk("n_zero.writes", wr_cnt, 0);
        chk("n_zero.sat_flag", int'(bus.sat_flag), 0);
        empty.name = "t_zero"; empty.samples = 4; empty.taps = 0;
        start_job(empty);
        wait_done("t_zero");
        chk("t_zero.busy_cycles", busy_cnt, 2);
        chk("t_zero.writes", wr_cnt, 0);

        // start and cfg changes while busy must not disturb the running job
        start_job(avg);
        repeat (4) @(negedge clk);
        bus.cfg_taps    = 6'd1;
        bus.cfg_samples = 14'd2;
        bus.cfg_decim   = 4'd3;
        bus.start       = 1'b1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_done("busy_start");
        avg.name = "busy_start";
        check_job(avg);
        @(negedge clk);
        chk("busy_start.idle_after", int'(bus.busy), 0);

        // reset during the MAC phase of output 2
        avg.name = "rerun";
        start_job(avg);
        begin
            int n = 0;
            while (!(bus.res_wr && bus.res_addr == 14'd1) && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("midrst.reached_write1", int'(bus.res_wr), 1);
        end
        @(negedge clk);
        chk("midrst.in_mac_busy", int'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst.writes_frozen", wr_cnt, 2);
        chk("midrst.idle_busy", int'(bus.busy), 0);
        start_job(avg);
        wait_done("rerun");
        check_job(avg);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
